// File: rtl/systolic_drain_deskew.sv
// systolic_drain_deskew: realigns the skewed bottom-edge outputs of the PE
// array into whole rows and buffers them in a small row FIFO that drains
// downstream over a valid/ready handshake. The array cannot stall, so rows
// that find the FIFO full are dropped and flagged on a sticky overflow.
module systolic_drain_deskew #(
   parameter int unsigned WORD_SIZE = 16,
   parameter int unsigned COLS      = 4,
   parameter int unsigned DEPTH     = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [COLS*WORD_SIZE-1:0]      col_in,
   input  logic                           in_valid,
   input  logic                           flush,
   input  logic                           clear_ovf,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [COLS*WORD_SIZE-1:0]      out_data,
   output logic [$clog2(DEPTH+1)-1:0]     fill,
   output logic                           overflow
);

   localparam int unsigned ROW_W  = COLS * WORD_SIZE;
   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned FILL_W = $clog2(DEPTH + 1);

   logic [ROW_W-1:0]  aligned_row;
   logic              aligned_valid;

   logic [ROW_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [FILL_W-1:0] fill_nxt;
   logic              do_pop;
   logic              do_push;
   logic              do_drop;

   // Per-column delay lines: column j waits COLS-1-j cycles so every word of
   // a row lands on the aligned bus in the same cycle.
   for (genvar j = 0; j < COLS; j++) begin : g_col
      localparam int unsigned STAGES = COLS - 1 - j;

      if (STAGES == 0) begin : g_direct
         assign aligned_row[j*WORD_SIZE +: WORD_SIZE] = col_in[j*WORD_SIZE +: WORD_SIZE];
      end else begin : g_pipe
         logic [WORD_SIZE-1:0] sr [STAGES];

         // Shift the column word down its delay line.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int k = 0; k < STAGES; k++) begin
                  sr[k] <= '0;
               end
            end else begin
               sr[0] <= col_in[j*WORD_SIZE +: WORD_SIZE];
               for (int k = 1; k < STAGES; k++) begin
                  sr[k] <= sr[k-1];
               end
            end
         end

         assign aligned_row[j*WORD_SIZE +: WORD_SIZE] = sr[STAGES-1];
      end
   end

   // The row marker follows column 0, so it needs the full COLS-1 stages.
   if (COLS == 1) begin : g_vld_direct
      assign aligned_valid = in_valid;
   end else begin : g_vld_pipe
      logic [COLS-2:0] vld_sr;

      // Shift the row marker; flush kills every row still in flight.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_sr <= '0;
         end else if (flush) begin
            vld_sr <= '0;
         end else begin
            vld_sr[0] <= in_valid;
            for (int k = 1; k < COLS - 1; k++) begin
               vld_sr[k] <= vld_sr[k-1];
            end
         end
      end

      assign aligned_valid = vld_sr[COLS-2];
   end

   // Handshake decode: a full FIFO still accepts a row when the head leaves
   // on the same edge; flush overrides both directions.
   always_comb begin
      do_pop  = 1'b0;
      do_push = 1'b0;
      do_drop = 1'b0;
      if (!flush) begin
         do_pop  = out_valid & out_ready;
         do_push = aligned_valid & ((fill < FILL_W'(DEPTH)) | do_pop);
         do_drop = aligned_valid & ~do_push;
      end
   end

   // Next occupancy count.
   always_comb begin
      fill_nxt = fill;
      if (flush) begin
         fill_nxt = '0;
      end else if (do_push && !do_pop) begin
         fill_nxt = fill + FILL_W'(1);
      end else if (do_pop && !do_push) begin
         fill_nxt = fill - FILL_W'(1);
      end
   end

   // Occupancy, registered head-valid and wrapping pointers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill      <= '0;
         out_valid <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
      end else begin
         fill      <= fill_nxt;
         out_valid <= (fill_nxt != '0);
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (do_push) begin
               wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
               rd_ptr <= rd_ptr + PTR_W'(1);
            end
         end
      end
   end

   // Row storage; only the tail slot is written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (do_push) begin
         mem[wr_ptr] <= aligned_row;
      end
   end

   // Sticky drop flag; a drop on the same edge as a clear keeps it set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (do_drop) begin
         overflow <= 1'b1;
      end else if (clear_ovf) begin
         overflow <= 1'b0;
      end
   end

   assign out_data = mem[rd_ptr];

endmodule

// File: tb/tb_systolic_drain_deskew.sv
// Bench for systolic_drain_deskew: directed scenarios plus a random soak,
// checked every cycle against a history-based row model.
module tb_systolic_drain_deskew;

   localparam int W     = 16;
   localparam int C     = 4;
   localparam int D     = 4;
   localparam int ROW_W = C * W;
   localparam int HN    = 8192;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [ROW_W-1:0] col_in = '0;
   logic             in_valid = 1'b0;
   logic             flush = 1'b0;
   logic             clear_ovf = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [ROW_W-1:0] out_data;
   logic [2:0]       fill;
   logic             overflow;

   int n_tests = 0;
   int n_fail  = 0;

   systolic_drain_deskew #(.WORD_SIZE(W), .COLS(C), .DEPTH(D)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .col_in    (col_in),
      .in_valid  (in_valid),
      .flush     (flush),
      .clear_ovf (clear_ovf),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .fill      (fill),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A row announced at cycle t is assembled from column j at cycle t+j and
   // enters the row queue at the end of cycle t+C-1 unless a flush occurred
   // anywhere in cycles t..t+C-1.
   logic [ROW_W-1:0] hist_col [HN];
   bit               hist_v   [HN];
   bit               hist_f   [HN];
   int               cyc  = 0;
   int               base = 0;
   logic [ROW_W-1:0] mq [$];
   bit               m_ovf = 1'b0;
   bit               m_al, m_acc, m_pop;
   int               m_t;
   logic [ROW_W-1:0] m_row;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_ovf = 1'b0;
         base  = cyc;
      end else begin
         hist_col[cyc] = col_in;
         hist_v[cyc]   = in_valid;
         hist_f[cyc]   = flush;
         m_t  = cyc - (C - 1);
         m_al = 1'b0;
         m_row = '0;
         if (m_t >= base && hist_v[m_t]) begin
            m_al = 1'b1;
            for (int k = m_t; k <= cyc; k++) if (hist_f[k]) m_al = 1'b0;
            for (int j = 0; j < C; j++) m_row[j*W +: W] = hist_col[m_t+j][j*W +: W];
         end
         m_pop = (mq.size() != 0) && out_ready;
         if (clear_ovf) m_ovf = 1'b0;
         if (flush) begin
            mq.delete();
         end else begin
            m_acc = m_al && ((mq.size() < D) || m_pop);
            if (m_al && !m_acc) m_ovf = 1'b1;
            if (m_pop) void'(mq.pop_front());
            if (m_acc) mq.push_back(m_row);
         end
         cyc++;
      end
   end

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
         chk("fill", 64'(fill), 64'(mq.size()));
         chk("overflow", 64'(overflow), 64'(m_ovf));
         if (mq.size() != 0) chk("out_data", out_data, mq[0]);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [ROW_W-1:0] exp_row(input int tag, input int r);
      logic [ROW_W-1:0] v;
      for (int j = 0; j < C; j++) v[j*W +: W] = 16'(tag + r*16 + j);
      return v;
   endfunction

   // Inputs for relative cycle c of a burst of n rows starting at cycle 0.
   task automatic drive(input int c, input int n, input int tag, input bit ff);
      logic [ROW_W-1:0] v;
      int r;
      in_valid = (c >= 0 && c < n);
      v = {$urandom(), $urandom()};
      for (int j = 0; j < C; j++) begin
         r = c - j;
         if (r >= 0 && r < n) v[j*W +: W] = 16'(tag + r*16 + j);
         else if (ff)         v[j*W +: W] = 16'hFFFF;
      end
      col_in = v;
   endtask

   task automatic idle();
      in_valid = 1'b0; flush = 1'b0; clear_ovf = 1'b0;
   endtask

   int vcount;

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_fill", 64'(fill), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      rst_n = 1'b1;
      repeat (3) step();

      // Single row
      out_ready = 1'b1;
      for (int c = 0; c < 7; c++) begin
         drive(c, 1, 'h100, 1'b1);
         step();
         if (c + 1 == 4) begin
            chk("single_valid", 64'(out_valid), 64'd1);
            chk("single_data", out_data, 64'h0103_0102_0101_0100);
         end else begin
            chk("single_novalid", 64'(out_valid), 64'd0);
         end
      end
      chk("single_fill0", 64'(fill), 64'd0);

      // Streaming
      vcount = 0;
      for (int c = 0; c < 13; c++) begin
         drive(c, 8, 0, 1'b0);
         step();
         if (out_valid) vcount++;
         if (c + 1 == 4) chk("stream_first", out_data, 64'h0003_0002_0001_0000);
         chk("stream_fill_le1", 64'(fill <= 1), 64'd1);
      end
      chk("stream_count", 64'(vcount), 64'd8);
      chk("stream_ovf", 64'(overflow), 64'd0);

      // Backpressure / overflow
      out_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         drive(c, 5, 'h200, 1'b0);
         step();
      end
      chk("bp_fill4", 64'(fill), 64'd4);
      chk("bp_ovf", 64'(overflow), 64'd1);
      idle();
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("bp_drain_data", out_data, exp_row('h200, k));
         step();
      end
      chk("bp_empty", 64'(out_valid), 64'd0);
      clear_ovf = 1'b1;
      step();
      clear_ovf = 1'b0;
      chk("bp_clear_ovf", 64'(overflow), 64'd0);

      // Full with simultaneous pop
      for (int c = 0; c < 13; c++) begin
         out_ready = (c >= 7);
         drive(c, 5, 'h300, 1'b0);
         step();
         if (c == 7) begin
            chk("fullpop_fill", 64'(fill), 64'd4);
            chk("fullpop_ovf", 64'(overflow), 64'd0);
         end
         if (c == 10) begin
            chk("fullpop_last", out_data, exp_row('h300, 4));
            chk("fullpop_fill1", 64'(fill), 64'd1);
         end
      end

      // Flush mid-flight
      for (int c = 0; c < 12; c++) begin
         out_ready = (c >= 7);
         flush = (c == 5);
         drive(c, 6, 'h400, 1'b0);
         step();
         if (c == 5) begin
            chk("flush_fill", 64'(fill), 64'd0);
            chk("flush_valid", 64'(out_valid), 64'd0);
            chk("flush_ovf", 64'(overflow), 64'd0);
         end
      end
      flush = 1'b0;
      chk("flush_none_valid", 64'(out_valid), 64'd0);

      // Async reset mid-operation
      out_ready = 1'b0;
      for (int c = 0; c < 7; c++) begin
         drive(c, 3, 'h500, 1'b0);
         step();
      end
      chk("ar_fill3", 64'(fill), 64'd3);
      idle();
      #2 rst_n = 1'b0;
      #1;
      chk("ar_valid", 64'(out_valid), 64'd0);
      chk("ar_fill", 64'(fill), 64'd0);
      chk("ar_ovf", 64'(overflow), 64'd0);
      chk("ar_data", out_data, 64'd0);
      #3 rst_n = 1'b1;
      step();
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         drive(c, 1, 'h600, 1'b0);
         step();
         if (c + 1 == 4) begin
            chk("ar_lat_valid", 64'(out_valid), 64'd1);
            chk("ar_lat_data", out_data, exp_row('h600, 0));
         end else begin
            chk("ar_lat_novalid", 64'(out_valid), 64'd0);
         end
      end

      // Random soak
      for (int c = 0; c < 600; c++) begin
         in_valid  = ($urandom_range(0, 99) < 55);
         col_in    = {$urandom(), $urandom()};
         out_ready = ($urandom_range(0, 99) < 45);
         flush     = ($urandom_range(0, 99) < 3);
         clear_ovf = ($urandom_range(0, 99) < 5);
         step();
      end
      idle();
      out_ready = 1'b1;
      repeat (10) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/systolic_drain_deskew.md
# systolic_drain_deskew

Collects results leaving the bottom edge of the systolic PE array and turns them back into aligned rows. Column j of the array emits its result j cycles after column 0. The block removes that skew, buffers complete rows in a small FIFO, and presents them downstream on a valid/ready handshake. It sits directly below the last PE row, fed by each column's `bottom_out`.

## Interface
Parameters:
- `WORD_SIZE`, 16: width of one PE result word.
- `COLS`, 4: number of array columns (≥1).
- `DEPTH`, 4: number of FIFO row entries (≥2, power of two).

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `col_in`, input, COLS*WORD_SIZE: bottom-row PE outputs. Column j occupies bits [j*WORD_SIZE +: WORD_SIZE].
- `in_valid`, input, 1: marks that column 0 carries a row's first word this cycle.
- `flush`, input, 1: synchronous clear of the skew pipeline valid and the FIFO.
- `clear_ovf`, input, 1: synchronous clear of `overflow`.
- `out_valid`, output, 1: head row available.
- `out_ready`, input, 1: downstream accepts the head row.
- `out_data`, output, COLS*WORD_SIZE: head row, same column packing as `col_in`.
- `fill`, output, $clog2(DEPTH+1): number of rows stored.
- `overflow`, output, 1: sticky; an aligned row was dropped.

## Operation
- **Deskew:**
  - Column j passes through COLS-1-j register stages.
  - `in_valid` passes through COLS-1 stages.
  - Stage outputs for all columns and for valid are then time-aligned. For COLS=1 the path is combinational and adds no stage.
- **Push:** when the aligned valid is 1, the aligned row is written into the FIFO tail on the next edge.
  - The write is accepted if `fill < DEPTH`, or if a pop occurs on the same edge.
  - Otherwise the row is dropped and `overflow` is set to 1. The array cannot stall, so there is no backpressure upstream.
- **Pop:** `out_valid && out_ready` at an edge removes the head row.
- **Fill update per edge:** +1 on push only, -1 on pop only, unchanged on push+pop.
- **out_data:**
  - Driven from the head storage slot.
  - Held stable while `out_valid=1` and `out_ready=0`.
  - Only meaningful when `out_valid=1`.
- **out_valid:** equals `fill != 0`.
- **flush:**
  - Clears every valid stage and empties the FIFO: `fill`→0, pointers→0.
  - Has priority over push and pop on the same edge.
  - Does not clear `overflow`. Data registers need not be cleared.
- **overflow:**
  - Set on a dropped row.
  - Cleared by `clear_ovf`.
  - If a set and a clear occur on the same edge, the set wins.
- **Pointers:** read and write pointers wrap modulo DEPTH.
- **No arithmetic:** data is transported bit-exact.

## Timing
- Reset values: `out_valid`=0, `out_data`=0 (all storage reset to 0), `fill`=0, `overflow`=0. All valid stages are 0.
- Latency: with `in_valid`=1 in cycle t and FIFO empty, `out_valid`=1 in cycle t+COLS, with `out_data` equal to {col j sampled at cycle t+j}.
- Throughput: one row per cycle in and out. Back-to-back `in_valid` with `out_ready`=1 produces back-to-back `out_valid` with no bubbles.
- Full with simultaneous pop: the push is accepted, `fill` stays at DEPTH, and there is no overflow.
- Empty: a push is visible on `out_valid` the cycle after the write edge. There is no combinational bypass from `col_in` to `out_data`.
- Reset asserted mid-operation immediately returns all outputs to their reset values. In-flight rows are lost.
- `out_ready` has no combinational path to `out_valid` or `out_data`.

## Test plan
All tests use WORD_SIZE=16, COLS=4, DEPTH=4.
- **Single row:** pulse `in_valid` at cycle 10 and drive column j with 0x0100+j at cycle 10+j (other cycles 0xFFFF), `out_ready`=1 → `out_valid`=1 only at cycle 14, `out_data`={0x0103,0x0102,0x0101,0x0100}, `fill` returns to 0.
- **Streaming:** 8 consecutive rows whose words encode row·16+col, `out_ready`=1 → 8 consecutive `out_valid` cycles, rows in order, `fill` ≤1, `overflow`=0.
- **Backpressure/overflow:** `out_ready`=0 with 5 rows sent → `fill`=4, and the 5th row is dropped with `overflow`=1 from the edge of its push. Then `out_ready`=1 → rows 0-3 drained in order. `clear_ovf` then sets `overflow`=0.
- **Full + simultaneous pop:** fill to 4, then assert `out_ready`=1 on the same cycle a 5th aligned row arrives → `fill` stays 4, `overflow`=0, and the 5th row appears last.
- **Flush mid-flight:** rows in both the skew pipeline and the FIFO, then `flush` for 1 cycle → `fill`=0, `out_valid`=0 next cycle, and the in-flight rows never appear. `overflow` is unchanged.
- **Async reset:** drop `rst_n` between edges while `fill`=3 → `out_valid`, `fill`, `overflow`, `out_data` read 0 immediately. After release, a new row completes with latency 4.
